// File: rtl/operand_pkg.sv
// rtl/operand_pkg.sv - shared types and bus-width constants for the operand datapath
package operand_pkg;

  // Shared with the add/sub operand mux so both ends agree on bus width.
  localparam int OPERAND_WIDTH = 3;
  localparam int PAIR_CNT_W    = 8;

  typedef enum logic [1:0] {
    LOAD_X,
    LOAD_Y,
    HOLD
  } demux_state_t;

endpackage

// File: rtl/operand_demux_if.sv
// rtl/operand_demux_if.sv - operand input stream and completed-pair output bundle
interface operand_demux_if #(
  parameter int WIDTH = operand_pkg::OPERAND_WIDTH,
  parameter int CNT_W = operand_pkg::PAIR_CNT_W
);
  logic [WIDTH:0]   in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sub_in;
  logic             clear;
  logic [WIDTH:0]   X;
  logic [WIDTH:0]   Y;
  logic             Sub;
  logic             pair_valid;
  logic             pair_ready;
  logic [CNT_W-1:0] pair_count;

  modport master (
    output in_data, in_valid, sub_in, clear, pair_ready,
    input  in_ready, X, Y, Sub, pair_valid, pair_count
  );

  modport slave (
    input  in_data, in_valid, sub_in, clear, pair_ready,
    output in_ready, X, Y, Sub, pair_valid, pair_count
  );
endinterface

// File: rtl/operand_demux.sv
// rtl/operand_demux.sv - steers an operand stream into X/Y registers and hands off the pair
module operand_demux
  import operand_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH,
  parameter int CNT_W = PAIR_CNT_W
) (
  input logic            clk,
  input logic            reset,
  operand_demux_if.slave bus
);

  demux_state_t     state_q;
  demux_state_t     state_d;
  logic [WIDTH:0]   x_q;
  logic [WIDTH:0]   y_q;
  logic             sub_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready;
  logic             load_x;
  logic             load_y;
  logic             consume;

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    load_x  = 1'b0;
    load_y  = 1'b0;
    consume = 1'b0;
    case (state_q)
      LOAD_X: begin
        ready = !bus.clear;
        if (bus.in_valid && ready) begin
          load_x  = 1'b1;
          state_d = LOAD_Y;
        end
      end
      LOAD_Y: begin
        ready = !bus.clear;
        if (bus.in_valid && ready) begin
          load_y  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Only a consumed pair frees the X register for a back-to-back load.
        ready = bus.pair_ready && !bus.clear;
        if (bus.pair_ready && !bus.clear) begin
          consume = 1'b1;
          if (bus.in_valid) begin
            load_x  = 1'b1;
            state_d = LOAD_Y;
          end else begin
            state_d = LOAD_X;
          end
        end
      end
      default: state_d = LOAD_X;
    endcase
    if (bus.clear) begin
      state_d = LOAD_X;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_X;
      x_q     <= '0;
      y_q     <= '0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_x) begin
        x_q <= bus.in_data;
      end
      if (load_y) begin
        y_q   <= bus.in_data;
        sub_q <= bus.sub_in;
      end
      if (consume) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.X          = x_q;
  assign bus.Y          = y_q;
  assign bus.Sub        = sub_q;
  assign bus.pair_valid = (state_q == HOLD);
  assign bus.pair_count = cnt_q;

endmodule
